rank_enc_sched: RTL and testbench

- Sequences the rank-order pixel encoder: accepts an image from the host, kicks the encoder, and serialises each sorted pixel index onto the AER output bus.
- Uses a 4-phase REQ/ACK handshake on the AER bus.
- Throttles the encoder through its busy input, counts emitted events and reports image completion and protocol errors.
- Sits between the host image interface, the encoder and the AER output to the neuromorphic core.

---
 rtl/rank_enc_pkg.sv | 18 +
 rtl/aer_sync2.sv | 22 ++
 rtl/rank_enc_sched.sv | 144 ++++++++++++++
 tb/tb_rank_enc_sched.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rank_enc_pkg.sv
// Shared types and default parameters for the rank-order encoder scheduler.
package rank_enc_pkg;

  localparam int DEF_IMAGE_SIZE  = 5;
  localparam int DEF_AER_ADDR_W  = 8;
  localparam int DEF_ADDR_BASE   = 0;
  localparam int DEF_ACK_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    ENCODE = 3'd2,
    REQ    = 3'd3,
    REL    = 3'd4,
    FINISH = 3'd5
  } state_t;

endpackage

// File: rtl/aer_sync2.sv
// Two-flop synchroniser for the asynchronous AER acknowledge; resets to 0.
module aer_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rank_enc_sched.sv
// Rank-order encoder scheduler: host image accept, encoder kick, 4-phase AER output.
// Optional per-phase ACK watchdog enabled by defining AER_TIMEOUT_EN.
module rank_enc_sched
  import rank_enc_pkg::*;
#(
  parameter int IMAGE_SIZE      = DEF_IMAGE_SIZE,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int AER_ADDR_W      = DEF_AER_ADDR_W,
  parameter int ADDR_BASE       = DEF_ADDR_BASE,
  parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   IMG_VALID,
  output logic                   IMG_READY,
  output logic                   ENC_START,
  input  logic                   ENC_FOUND,
  input  logic [IMAGE_SIZE_BITS:0] ENC_INDEX,
  input  logic                   ENC_DONE,
  output logic                   ENC_BUSY,
  output logic [AER_ADDR_W-1:0]  AEROUT_ADDR,
  output logic                   AEROUT_REQ,
  input  logic                   AEROUT_ACK,
  output logic [IMAGE_SIZE_BITS:0] EVT_CNT,
  output logic                   IMG_DONE,
  output logic                   ERR
);

  localparam int IDX_W = IMAGE_SIZE_BITS + 1;
  localparam logic [IDX_W-1:0]      CNT_MAX = IDX_W'(IMAGE_SIZE);
  localparam logic [AER_ADDR_W-1:0] BASE    = AER_ADDR_W'(ADDR_BASE);

  if (AER_ADDR_W < IDX_W || ACK_TIMEOUT < 1) begin : g_bad_cfg
    $error("rank_enc_sched: AER_ADDR_W too narrow or ACK_TIMEOUT < 1");
  end

  state_t state, state_nxt;
  logic   ack_s;
  logic   done_pend;
  logic   timeout;
  logic   evt_exit;

  aer_sync2 u_ack_sync (
    .clk   (CLK),
    .rst_n (RSTN),
    .d     (AEROUT_ACK),
    .q     (ack_s)
  );

`ifdef AER_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt;

  // Counts cycles spent in the current handshake phase; restarts on any transition.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      to_cnt <= '0;
    else if (state != state_nxt || !(state inside {REQ, REL}))
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign timeout = (state inside {REQ, REL}) && (to_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  assign evt_exit = ((state == REQ) && timeout) ||
                    ((state == REL) && (timeout || !ack_s));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (IMG_VALID) state_nxt = START;
      START:   state_nxt = ENCODE;
      ENCODE:  if (ENC_FOUND)     state_nxt = REQ;
               else if (ENC_DONE) state_nxt = FINISH;
      REQ:     if (evt_exit)      state_nxt = done_pend ? FINISH : ENCODE;
               else if (ack_s)    state_nxt = REL;
      REL:     if (evt_exit)      state_nxt = done_pend ? FINISH : ENCODE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    IMG_READY  = 1'b0;
    ENC_START  = 1'b0;
    AEROUT_REQ = 1'b0;
    IMG_DONE   = 1'b0;
    unique case (state)
      IDLE:    IMG_READY  = 1'b1;
      START:   ENC_START  = 1'b1;
      REQ:     AEROUT_REQ = 1'b1;
      FINISH:  IMG_DONE   = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      AEROUT_ADDR <= '0;
      ENC_BUSY    <= 1'b0;
      EVT_CNT     <= '0;
      ERR         <= 1'b0;
      done_pend   <= 1'b0;
    end else begin
      if (state == IDLE && IMG_VALID) begin
        EVT_CNT   <= '0;
        done_pend <= 1'b0;
      end
      // FOUND wins over a coincident DONE; the DONE is parked until the handshake ends.
      if (state == ENCODE && ENC_FOUND) begin
        AEROUT_ADDR <= BASE + AER_ADDR_W'(ENC_INDEX);
        ENC_BUSY    <= 1'b1;
        if (ENC_DONE) begin
          done_pend <= 1'b1;
          ERR       <= 1'b1;
        end
      end
      if ((state inside {REQ, REL}) && ENC_FOUND)
        ERR <= 1'b1;
      if (evt_exit) begin
        ENC_BUSY <= 1'b0;
        if (EVT_CNT != CNT_MAX) EVT_CNT <= EVT_CNT + 1'b1;
        if (timeout)            ERR     <= 1'b1;
      end
      if (state == FINISH) begin
        done_pend <= 1'b0;
        if (EVT_CNT != CNT_MAX) ERR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rank_enc_sched.sv
// Self-checking bench for rank_enc_sched: encoder and AER peer models plus an event-list reference.
module tb_rank_enc_sched;

  localparam int IMAGE_SIZE = 5;
  localparam int IW         = $clog2(IMAGE_SIZE) + 1;
  localparam int AW         = 8;
  localparam int BASE       = 16;
  localparam int TO         = 8;

  logic          CLK        = 1'b0;
  logic          RSTN       = 1'b0;
  logic          IMG_VALID  = 1'b0;
  logic          ENC_FOUND  = 1'b0;
  logic [IW-1:0] ENC_INDEX  = '0;
  logic          ENC_DONE   = 1'b0;
  logic          AEROUT_ACK = 1'b0;
  logic          IMG_READY, ENC_START, ENC_BUSY, AEROUT_REQ, IMG_DONE, ERR;
  logic [AW-1:0] AEROUT_ADDR;
  logic [IW-1:0] EVT_CNT;

  rank_enc_sched #(
    .IMAGE_SIZE  (IMAGE_SIZE),
    .AER_ADDR_W  (AW),
    .ADDR_BASE   (BASE),
    .ACK_TIMEOUT (TO)
  ) dut (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .IMG_VALID   (IMG_VALID),
    .IMG_READY   (IMG_READY),
    .ENC_START   (ENC_START),
    .ENC_FOUND   (ENC_FOUND),
    .ENC_INDEX   (ENC_INDEX),
    .ENC_DONE    (ENC_DONE),
    .ENC_BUSY    (ENC_BUSY),
    .AEROUT_ADDR (AEROUT_ADDR),
    .AEROUT_REQ  (AEROUT_REQ),
    .AEROUT_ACK  (AEROUT_ACK),
    .EVT_CNT     (EVT_CNT),
    .IMG_DONE    (IMG_DONE),
    .ERR         (ERR)
  );

  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;
  bit exp_err     = 1'b0;
  int peer_delay  = 3;
  bit peer_on     = 1'b1;

  // Monitor: counters only ever grow; scenarios work from snapshots.
  logic          prev_req  = 1'b0;
  logic [AW-1:0] held_addr = '0;
  logic [AW-1:0] got_addr[$];
  int done_pulses = 0, start_pulses = 0, stable_viol = 0, busy_viol = 0;

  always @(negedge CLK) begin
    if (AEROUT_REQ && !prev_req) got_addr.push_back(AEROUT_ADDR);
    else if (AEROUT_REQ && AEROUT_ADDR !== held_addr) stable_viol++;
    if (AEROUT_REQ && ENC_BUSY !== 1'b1) busy_viol++;
    if (IMG_DONE)  done_pulses++;
    if (ENC_START) start_pulses++;
    prev_req  <= AEROUT_REQ;
    held_addr <= AEROUT_ADDR;
  end

  // AER peer: mirrors REQ onto ACK a fixed number of cycles after each edge.
  always begin
    @(posedge CLK);
    #1;
    if (peer_on && AEROUT_ACK !== AEROUT_REQ) begin
      repeat (peer_delay) @(posedge CLK);
      #1;
      AEROUT_ACK = AEROUT_REQ;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic shuffle(output int q[$]);
    q = {};
    for (int i = 0; i < IMAGE_SIZE; i++) q.push_back(i);
    for (int i = IMAGE_SIZE - 1; i > 0; i--) begin
      int j;
      int t;
      j    = $urandom_range(i, 0);
      t    = q[i];
      q[i] = q[j];
      q[j] = t;
    end
  endtask

  task automatic apply_reset();
    RSTN = 1'b0;
    repeat (2) tick();
    RSTN = 1'b1;
    exp_err = 1'b0;
    tick();
  endtask

  // Plays one image through the encoder model and compares the observed AER stream with the reference.
  task automatic play_image(input string name, input int idx[$], input int n_ev,
                            input int inject_at, input bit done_last, input bit expect_to);
    int n, q0, d0, s0, sv0, bv0, exp_cnt;
    bit ok;
    logic [AW-1:0] exp_addr, inj_seen;
    ok = 1'b1;
    inj_seen = '0;
    q0 = got_addr.size(); d0 = done_pulses; s0 = start_pulses;
    sv0 = stable_viol; bv0 = busy_viol;
    n = 0;
    while (IMG_READY !== 1'b1 && n < 500) begin tick(); n++; end
    IMG_VALID = 1'b1; tick(); IMG_VALID = 1'b0; tick();
    for (int k = 0; k < n_ev && ok; k++) begin
      n = 0;
      while (ENC_BUSY !== 1'b0 && n < 2000) begin tick(); n++; end
      if (ENC_BUSY !== 1'b0) ok = 1'b0;
      else begin
        ENC_FOUND = 1'b1;
        ENC_INDEX = IW'(idx[k]);
        ENC_DONE  = done_last && (k == n_ev - 1);
        tick();
        ENC_FOUND = 1'b0;
        ENC_DONE  = 1'b0;
        if (k == inject_at) begin
          n = 0;
          while (AEROUT_REQ !== 1'b0 && n < 2000) begin tick(); n++; end
          ENC_FOUND = 1'b1;
          ENC_INDEX = IW'((idx[k] + 1) % IMAGE_SIZE);
          tick();
          ENC_FOUND = 1'b0;
          inj_seen  = AEROUT_ADDR;
        end
      end
    end
    n = 0;
    while (ok && ENC_BUSY !== 1'b0 && n < 2000) begin tick(); n++; end
    if (ok && !done_last) begin ENC_DONE = 1'b1; tick(); ENC_DONE = 1'b0; end
    n = 0;
    while (IMG_READY !== 1'b1 && n < 2000) begin tick(); n++; end
    if (IMG_READY !== 1'b1) ok = 1'b0;
    tick();

    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s progress: wait bound expired, got stalled expected completion", name);
    end
    vectors++;
    if (got_addr.size() - q0 !== n_ev) begin
      miscompares++;
      $display("FAIL %s event_count_on_bus: got %0d expected %0d", name, got_addr.size() - q0, n_ev);
    end
    for (int k = 0; k < n_ev && q0 + k < got_addr.size(); k++) begin
      exp_addr = AW'(BASE + idx[k]);
      vectors++;
      if (got_addr[q0 + k] !== exp_addr) begin
        miscompares++;
        $display("FAIL %s addr[%0d]: got %0d expected %0d", name, k, got_addr[q0 + k], exp_addr);
      end
    end
    exp_cnt = (n_ev < IMAGE_SIZE) ? n_ev : IMAGE_SIZE;
    vectors++;
    if (EVT_CNT !== IW'(exp_cnt)) begin
      miscompares++;
      $display("FAIL %s evt_cnt: got %0d expected %0d", name, EVT_CNT, exp_cnt);
    end
    if (exp_cnt != IMAGE_SIZE || inject_at >= 0 || done_last || expect_to) exp_err = 1'b1;
    vectors++;
    if (ERR !== exp_err) begin
      miscompares++;
      $display("FAIL %s err: got %b expected %b", name, ERR, exp_err);
    end
    vectors++;
    if (done_pulses - d0 !== 1 || start_pulses - s0 !== 1) begin
      miscompares++;
      $display("FAIL %s pulses: got done=%0d start=%0d expected 1 and 1",
               name, done_pulses - d0, start_pulses - s0);
    end
    vectors++;
    if (stable_viol - sv0 !== 0 || busy_viol - bv0 !== 0) begin
      miscompares++;
      $display("FAIL %s addr_stable/busy_held: got %0d/%0d violations expected 0/0",
               name, stable_viol - sv0, busy_viol - bv0);
    end
    if (inject_at >= 0) begin
      exp_addr = AW'(BASE + idx[inject_at]);
      vectors++;
      if (inj_seen !== exp_addr) begin
        miscompares++;
        $display("FAIL %s addr_after_inject: got %0d expected %0d", name, inj_seen, exp_addr);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_vals [8];
    logic [7:0] got_vals [8];
    RSTN = 1'b0;
    repeat (3) tick();
    got_vals = '{8'(IMG_READY), 8'(ENC_START), 8'(ENC_BUSY), AEROUT_ADDR,
                 8'(AEROUT_REQ), 8'(EVT_CNT), 8'(IMG_DONE), 8'(ERR)};
    exp_vals = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got_vals[i] !== exp_vals[i]) begin
        miscompares++;
        $display("FAIL reset_out[%0d]: got %0d expected %0d", i, got_vals[i], exp_vals[i]);
      end
    end
    RSTN = 1'b1;
    exp_err = 1'b0;
    repeat (2) tick();
    vectors++;
    if (IMG_READY !== 1'b1 || ENC_START !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_hold: got ready=%b start=%b expected 1 0", IMG_READY, ENC_START);
    end
  endtask

  task automatic test_basic();
    peer_delay = 3;
    play_image("basic", '{3, 0, 4, 1, 2}, 5, -1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int q[$];
    for (int it = 0; it < 4; it++) begin
      shuffle(q);
      peer_delay = $urandom_range(6, 1);
      play_image($sformatf("random%0d", it), q, 5, -1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_slow_peer();
    int q[$];
    shuffle(q);
    peer_delay = 50;
    play_image("slow_peer", q, 5, -1, 1'b0, 1'b0);
    peer_delay = 3;
  endtask

  task automatic test_short_image();
    int q[$];
    shuffle(q);
    play_image("short_image", q, 4, -1, 1'b0, 1'b0);
    shuffle(q);
    play_image("err_sticky", q, 5, -1, 1'b0, 1'b0);
    apply_reset();
  endtask

  task automatic test_found_in_rel();
    int q[$];
    shuffle(q);
    play_image("found_in_rel", q, 5, $urandom_range(3, 0), 1'b0, 1'b0);
    apply_reset();
  endtask

  task automatic test_found_with_done();
    int q[$];
    shuffle(q);
    play_image("found_with_done", q, 5, -1, 1'b1, 1'b0);
    apply_reset();
  endtask

  task automatic test_reset_mid();
    int q[$];
    int n;
    n = 0;
    while (IMG_READY !== 1'b1 && n < 500) begin tick(); n++; end
    IMG_VALID = 1'b1; tick(); IMG_VALID = 1'b0; tick();
    ENC_FOUND = 1'b1; ENC_INDEX = IW'(2); tick(); ENC_FOUND = 1'b0;
    vectors++;
    if (AEROUT_REQ !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_req_before: got %b expected 1", AEROUT_REQ);
    end
    #2 RSTN = 1'b0;
    #1;
    vectors++;
    if (AEROUT_REQ !== 1'b0 || IMG_READY !== 1'b1 || ENC_BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got req=%b ready=%b busy=%b expected 0 1 0",
               AEROUT_REQ, IMG_READY, ENC_BUSY);
    end
    exp_err = 1'b0;
    repeat (2) tick();
    RSTN = 1'b1;
    repeat (8) tick();
    shuffle(q);
    play_image("after_reset", q, 5, -1, 1'b0, 1'b0);
  endtask

`ifdef AER_TIMEOUT_EN
  task automatic test_timeout();
    int q[$];
    shuffle(q);
    peer_on = 1'b0;
    play_image("ack_timeout", q, 5, -1, 1'b0, 1'b1);
    peer_on = 1'b1;
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_slow_peer();
    test_short_image();
    test_found_in_rel();
    test_found_with_done();
    test_reset_mid();
`ifdef AER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
